sync_down_counter: RTL and testbench
====================================

// Module: sync_down_counter
// PURPOSE
//   Loadable synchronous down counter (countdown timer): preset value, counts down to zero
//   on prescaled ticks, pulses terminal count. Complements the lab up counter; drives LEDR
//   on the board top from KEY/SW controls and serves as a timebase for later lab FSMs.
// PARAMETERS
//   WIDTH          4   count width in bits
//   PRESCALE_BITS  24  tick every 2**PRESCALE_BITS clk cycles in RUN; 0 = tick every cycle (sim)
// PORTS
//   clk         in   1      system clock (CLOCK_50 at top)
//   reset_n     in   1      asynchronous reset, active-low
//   load        in   1      1-cycle strobe: preset count from load_value
//   load_value  in   WIDTH  preset value
//   start       in   1      1-cycle strobe: begin/resume counting
//   pause       in   1      1-cycle strobe: freeze counting
//   count       out  WIDTH  current count (registered)
//   zero        out  1      count == 0 (combinational from count register)
//   busy        out  1      state == RUN (registered state decode)
//   tc_pulse    out  1      registered 1-cycle pulse on terminal count
// BEHAVIOUR
//   Reset (async, reset_n=0): count=0, reload_reg=0, prescaler=0, state=IDLE,
//     tc_pulse=0 -> zero=1, busy=0. Takes effect immediately mid-operation.
//   States: IDLE, RUN, PAUSE, DONE. All updates on posedge clk.
//   Priority per cycle: load > pause > start > tick.
//   load (any state): count<=load_value, reload_reg<=load_value, prescaler<=0, state->IDLE.
//   start: IDLE or PAUSE with count!=0 -> RUN. Ignored in RUN, DONE, or when count==0.
//   pause: RUN -> PAUSE; count and prescaler hold. Ignored in other states.
//   tick: prescaler increments only in RUN; tick=1 when prescaler is all ones
//     (always 1 when PRESCALE_BITS=0). Prescaler is cleared on entry to RUN.
//   RUN & tick & count>1: count<=count-1.
//   RUN & tick & count==1: tc_pulse<=1 for exactly one cycle. Terminal action per
//     CONFIGURATION. The pulse coincides with the first cycle the new count is visible.
//   Latency: a tick in cycle N is visible on count in cycle N+1. Start in cycle N gives
//     busy=1 in N+1, and the first decrement is visible in N+2 (PRESCALE_BITS=0).
//   No underflow: count never decrements below 0. No wrap from 0 to 2**WIDTH-1.
//   DONE: count holds 0 until load. start and pause are ignored.
// CONFIGURATION
//   AUTO_RELOAD_EN undefined: terminal action is count<=0, state->DONE.
//   AUTO_RELOAD_EN defined: terminal action is count<=reload_reg, state stays RUN (periodic
//     timer). DONE is unreachable. zero never asserts while running.
// STRUCTURE
//   Package sync_down_counter_pkg: typedef enum logic [1:0] {IDLE,RUN,PAUSE,DONE} cnt_state_t.
//   Sub-module down_prescaler (PRESCALE_BITS; inputs clk, reset_n, clr, run; output tick)
//   generates the tick. Counter, reload register and FSM live in sync_down_counter.
// TESTING  (WIDTH=4, PRESCALE_BITS=0 unless noted)
//   1 reset_n=0 then 1 -> count=0, zero=1, busy=0, tc_pulse=0.
//   2 load 5, then start -> count 5,4,3,2,1,0 on consecutive cycles. tc_pulse high only
//     with count=0. busy falls and the count holds at 0 in DONE. A start in DONE is ignored.
//   3 load 9, start, pause at count=6, idle 4 cycles -> count holds at 6.
//     start -> busy=1, then 5,4,...
//   4 load 0, start -> state IDLE, busy=0, no tc_pulse.
//     load 15 while RUN at 7 -> count=15, busy=0.
//   5 PRESCALE_BITS=2: load 3, start -> each value held 4 cycles. reset_n=0 at count=2
//     -> count=0 immediately, before the next clk edge.
//   6 +define+AUTO_RELOAD_EN: load 3, start -> count 3,2,1,3,2,1,... with tc_pulse
//     every 3rd cycle. busy stays 1 and zero stays 0.

Source files
------------

// File: rtl/sync_down_counter_pkg.sv
// rtl/sync_down_counter_pkg.sv - shared types for the loadable down counter
//
// Contents:
//   cnt_state_t  counter FSM state encoding (IDLE, RUN, PAUSE, DONE)
//
// Optional feature macro used by importers: AUTO_RELOAD_EN

package sync_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cnt_state_t;

endpackage

// File: rtl/sync_down_counter_prescaler.sv
// rtl/sync_down_counter_prescaler.sv - free-running tick prescaler for the down counter
//
// Ports:
//   clk      in   1  system clock
//   reset_n  in   1  asynchronous reset, active-low
//   clr      in   1  synchronous clear of the prescale count
//   run      in   1  advance the prescale count this cycle
//   tick     out  1  high while the prescale count is all ones (constant 1 when PRESCALE_BITS=0)

module down_prescaler #(
    parameter int PRESCALE_BITS = 24
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    generate
        if (PRESCALE_BITS == 0) begin : g_no_prescale
            // Every cycle is a tick; the control inputs have nothing to drive.
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset_n, clr, run};
            assign tick = 1'b1;
        end else begin : g_prescale
            logic [PRESCALE_BITS-1:0] pre_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pre_cnt <= '0;
                end else if (clr) begin
                    pre_cnt <= '0;
                end else if (run) begin
                    // Wraps from all ones back to zero, giving a tick every 2**PRESCALE_BITS runs.
                    pre_cnt <= pre_cnt + PRESCALE_BITS'(1);
                end
            end

            assign tick = &pre_cnt;
        end
    endgenerate

endmodule

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable down counter / countdown timer with terminal-count pulse
//
// Ports:
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous reset, active-low
//   load        in   1      strobe: preset count and reload register from load_value
//   load_value  in   WIDTH  preset value
//   start       in   1      strobe: begin/resume counting
//   pause       in   1      strobe: freeze counting
//   count       out  WIDTH  current count (registered)
//   zero        out  1      count == 0
//   busy        out  1      state == RUN
//   tc_pulse    out  1      one-cycle pulse when the count reaches its terminal value
//
// Optional feature: define AUTO_RELOAD_EN to reload from the preset on terminal
// count and keep running (periodic timer); otherwise the counter stops in DONE at 0.

module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int PRESCALE_BITS = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             tc_pulse
);

    cnt_state_t       state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt;
    logic             tc_nxt;
    logic             start_ok;
    logic             tick;
    logic             pre_clr;
    logic             pre_run;

    // Prescaler restarts on every load and on every entry to RUN, and only
    // advances in cycles where RUN actually continues (not on load/pause).
    assign pre_clr = load | start_ok;
    assign pre_run = (state == RUN) & ~load & ~pause;

    down_prescaler #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (pre_clr),
        .run     (pre_run),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc_pulse   <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            tc_pulse   <= tc_nxt;
        end
    end

    // Strobe priority: load > pause > start > tick.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;
        start_ok   = 1'b0;

        if (load) begin
            count_nxt  = load_value;
            reload_nxt = load_value;
            state_nxt  = IDLE;
        end else if (pause && (state == RUN)) begin
            state_nxt = PAUSE;
        end else if (start && ((state == IDLE) || (state == PAUSE)) && (count != '0)) begin
            state_nxt = RUN;
            start_ok  = 1'b1;
        end else if ((state == RUN) && tick) begin
            if (count > WIDTH'(1)) begin
                count_nxt = count - WIDTH'(1);
            end else begin
                // Terminal step from 1; a zero count in RUN is only handled
                // defensively and never produces a pulse.
                tc_nxt = (count == WIDTH'(1));
`ifdef AUTO_RELOAD_EN
                count_nxt = reload_reg;
`else
                count_nxt = '0;
                state_nxt = DONE;
`endif
            end
        end
    end

    assign zero = (count == '0);
    assign busy = (state == RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// tb/tb_sync_down_counter.sv - directed self-checking bench for sync_down_counter

module tb_sync_down_counter;

    localparam int W = 4;

    logic         clk;
    logic         reset_n;

    logic         load, start, pause;
    logic [W-1:0] load_value;
    logic [W-1:0] count;
    logic         zero, busy, tc_pulse;

    logic         p_load, p_start, p_pause;
    logic [W-1:0] p_load_value;
    logic [W-1:0] p_count;
    logic         p_zero, p_busy, p_tc_pulse;

    int n_cmp = 0;
    int n_err = 0;

    sync_down_counter #(.WIDTH(W), .PRESCALE_BITS(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count      (count),
        .zero       (zero),
        .busy       (busy),
        .tc_pulse   (tc_pulse)
    );

    sync_down_counter #(.WIDTH(W), .PRESCALE_BITS(2)) dut_ps (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (p_load),
        .load_value (p_load_value),
        .start      (p_start),
        .pause      (p_pause),
        .count      (p_count),
        .zero       (p_zero),
        .busy       (p_busy),
        .tc_pulse   (p_tc_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic [W-1:0] c, input logic b, input logic tc);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".tc"}, 32'(tc_pulse), 32'(tc));
        chk({tag, ".zero"}, 32'(zero), 32'(c == '0));
    endtask

    initial begin
        reset_n = 1'b0;
        load = 0; start = 0; pause = 0; load_value = '0;
        p_load = 0; p_start = 0; p_pause = 0; p_load_value = '0;

        // 1: reset state
        #12;
        chk_main("rst", 4'd0, 1'b0, 1'b0);
        chk("rst.ps_count", 32'(p_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        chk_main("rst_rel", 4'd0, 1'b0, 1'b0);

`ifndef AUTO_RELOAD_EN
        // 2: load 5, run to terminal, DONE holds, start ignored
        load = 1; load_value = 4'd5;
        cyc();
        load = 0;
        chk_main("t2.load", 4'd5, 1'b0, 1'b0);
        start = 1;
        cyc();
        start = 0;
        chk_main("t2.start", 4'd5, 1'b1, 1'b0);
        for (int v = 4; v >= 1; v--) begin
            cyc();
            chk_main("t2.down", W'(v), 1'b1, 1'b0);
        end
        cyc();
        chk_main("t2.term", 4'd0, 1'b0, 1'b1);
        cyc();
        chk_main("t2.done", 4'd0, 1'b0, 1'b0);
        start = 1;
        cyc();
        start = 0;
        chk_main("t2.done_start", 4'd0, 1'b0, 1'b0);
        cyc();
        chk_main("t2.done_hold", 4'd0, 1'b0, 1'b0);
`else
        // 6: periodic reload 3,2,1,3,2,1 with pulse on each reload
        load = 1; load_value = 4'd3;
        cyc();
        load = 0;
        start = 1;
        cyc();
        start = 0;
        chk_main("t6.start", 4'd3, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++) begin
            cyc();
            chk_main("t6.c2", 4'd2, 1'b1, 1'b0);
            cyc();
            chk_main("t6.c1", 4'd1, 1'b1, 1'b0);
            cyc();
            chk_main("t6.reload", 4'd3, 1'b1, 1'b1);
        end
`endif

        // 3: pause at 6, hold, resume
        load = 1; load_value = 4'd9;
        cyc();
        load = 0;
        start = 1;
        cyc();
        start = 0;
        chk_main("t3.start", 4'd9, 1'b1, 1'b0);
        for (int v = 8; v >= 6; v--) begin
            cyc();
            chk_main("t3.down", W'(v), 1'b1, 1'b0);
        end
        pause = 1;
        cyc();
        pause = 0;
        chk_main("t3.pause", 4'd6, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_main("t3.hold", 4'd6, 1'b0, 1'b0);
        end
        start = 1;
        cyc();
        start = 0;
        chk_main("t3.resume", 4'd6, 1'b1, 1'b0);
        cyc();
        chk_main("t3.r5", 4'd5, 1'b1, 1'b0);
        cyc();
        chk_main("t3.r4", 4'd4, 1'b1, 1'b0);

        // 4: start with zero count is ignored; load during RUN aborts to IDLE
        load = 1; load_value = 4'd0;
        cyc();
        load = 0;
        start = 1;
        cyc();
        start = 0;
        chk_main("t4.zero_start", 4'd0, 1'b0, 1'b0);
        cyc();
        chk_main("t4.zero_idle", 4'd0, 1'b0, 1'b0);
        load = 1; load_value = 4'd9;
        cyc();
        load = 0;
        start = 1;
        cyc();
        start = 0;
        cyc();
        cyc();
        chk_main("t4.at7", 4'd7, 1'b1, 1'b0);
        load = 1; load_value = 4'd15;
        cyc();
        load = 0;
        chk_main("t4.reload", 4'd15, 1'b0, 1'b0);
        cyc();
        chk_main("t4.idle", 4'd15, 1'b0, 1'b0);

        // 5: prescaled instance, each value held 4 cycles, async reset mid-run
        p_load = 1; p_load_value = 4'd3;
        cyc();
        p_load = 0;
        p_start = 1;
        cyc();
        p_start = 0;
        chk("t5.busy", 32'(p_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t5.hold3", 32'(p_count), 32'd3);
            if (i < 3) cyc();
        end
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t5.hold2", 32'(p_count), 32'd2);
            chk("t5.tc", 32'(p_tc_pulse), 32'd0);
            if (i < 3) cyc();
        end
        reset_n = 1'b0;
        #1;
        chk("t5.async_count", 32'(p_count), 32'd0);
        chk("t5.async_zero", 32'(p_zero), 32'd1);
        chk("t5.async_busy", 32'(p_busy), 32'd0);
        chk("t5.async_main", 32'(count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        chk("t5.post_rst", 32'(p_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
